sync_reg_reader: RTL and testbench
==================================

Name: sync_reg_reader

Overview:
Read-side consumer for the Sync_Reg clock-crossing register. It runs in the fast read-clock domain and watches the register's empty flag and data. Each new word is qualified (must stay stable for a settle window), then pushed into a small FIFO. Words are delivered downstream on a valid/ready handshake, with overflow and glitch reporting.

Parameters:
SIZE, 8, data width in bits; matches the SIZE of the Sync_Reg instance.
DEPTH, 4, FIFO depth in words; power of 2, at least 2.
SETTLE, 2, consecutive cycles in_empty must stay low after detection before capture; at least 1.

Ports:
clk  input  1  single clock; the Sync_Reg read clock.
rst  input  1  synchronous, active-high reset.
in_data  input  SIZE  Sync_Reg r_data.
in_empty  input  1  Sync_Reg r_empty; already in the clk domain, no extra synchronisation.
out_data  output  SIZE  FIFO head word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  downstream accept.
overflow  output  1  sticky; a qualified word was dropped because the FIFO was full.
ovf_clr  input  1  clears overflow.
glitch  output  1  one-cycle pulse; in_empty rose during the settle window.
rx_count  output  16  count of words pushed into the FIFO; wraps at 16'hFFFF to 0.
level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, sampled at clk edge while rst=1) sets the following:
  - state=IDLE; FIFO emptied; out_valid=0; out_data=0; overflow=0; glitch=0; rx_count=0; level=0.
  - Any in-flight word is discarded.
- Detection FSM:
  - IDLE: wait for in_empty=1, then go to ARMED. A stale low in_empty after reset is never captured.
  - ARMED: in_empty sampled 0 at edge E0 goes to SETTLE, with settle counter=0.
  - SETTLE: at each following edge:
    - in_empty=1: go to ARMED and pulse glitch for one cycle; no push.
    - otherwise increment the counter.
    - When the counter reaches SETTLE (edge E0+SETTLE), in_data sampled at that edge is the captured word; go to CAPTURE.
  - CAPTURE: single-cycle; the word was pushed at entry (or dropped, see overflow). Go to WAIT_EMPTY.
  - WAIT_EMPTY: stay until in_empty=1, then go to ARMED. Exactly one word per in_empty low period.
- Latency: with the FIFO empty, out_valid=1 and out_data = the captured word immediately after edge E0+SETTLE.
- FIFO behaviour:
  - First-word-fall-through; out_data is registered head-of-queue.
  - Pop on out_valid & out_ready at the edge.
  - Pointers wrap modulo DEPTH.
  - level is updated at the same edge as push/pop.
- Simultaneous push and pop:
  - With the FIFO full: both are performed; level unchanged; no overflow.
  - With the FIFO holding 1 word: the new word becomes head after the edge; out_valid stays 1.
- Overflow:
  - Push with level=DEPTH and no pop in the same cycle drops the word; overflow set at that edge; rx_count not incremented.
  - ovf_clr clears overflow at the next edge. If ovf_clr and a new drop occur in the same cycle, set wins.
- rx_count increments only on an accepted push.
- out_ready while out_valid=0 is ignored.
- Reset mid-SETTLE or mid-CAPTURE: word lost; FSM returns to IDLE and requires in_empty=1 before re-arming.
- in_data is ignored outside the capture edge.

Test Plan:
1. Single word: rst 3 cycles, in_empty=1 then in_data=8'hBB with in_empty=0 held 50 cycles, out_ready=1 -> out_valid high exactly 2 cycles after first low sample, out_data=8'hBB, one pop, rx_count=1, overflow=0.
2. Glitch: in_empty low 1 cycle then high (SETTLE=2) -> glitch pulses once, no push, level=0; next valid low period with 8'h3C is captured normally.
3. Fill/overflow: out_ready=0, five low periods with data 8'h01..8'h05 -> level=4, 8'h05 dropped, overflow=1, rx_count=4; then out_ready=1 -> out_data sequence 01,02,03,04; ovf_clr -> overflow=0.
4. Push+pop when full: FIFO full, out_ready=1 on the same edge as capture of 8'hA5 -> level stays 4, overflow=0, 8'hA5 read last.
5. Stale low after reset: in_empty=0 with 8'h77 during and after rst release -> no capture until in_empty goes 1 then 0 again.
6. Reset mid-SETTLE: rst asserted at E0+1 -> no push, level=0, rx_count=0, FSM in IDLE.

Source files
------------

// File: rtl/sync_reg_reader.sv
// sync_reg_reader
//   Read-side consumer for a Sync_Reg clock-crossing register. It watches the
//   register's empty flag and data, qualifies each new word over a settle
//   window, and pushes it into a small first-word-fall-through FIFO. Words are
//   delivered downstream on a valid/ready handshake.
//
// Ports
//   clk        read-domain clock
//   rst        synchronous, active-high reset
//   in_data    Sync_Reg r_data
//   in_empty   Sync_Reg r_empty (already in the clk domain)
//   out_data   registered FIFO head word
//   out_valid  FIFO non-empty
//   out_ready  downstream accept; a pop happens on out_valid & out_ready
//   overflow   sticky; a qualified word was dropped because the FIFO was full
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   glitch     one-cycle pulse; in_empty rose during the settle window
//   rx_count   words accepted into the FIFO, wrapping
//   level      current FIFO occupancy
module sync_reg_reader #(
   parameter int SIZE   = 8,
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SIZE-1:0]          in_data,
   input  logic                     in_empty,
   output logic [SIZE-1:0]          out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overflow,
   input  logic                     ovf_clr,
   output logic                     glitch,
   output logic [15:0]              rx_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(SETTLE + 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ARMED      = 3'd1;
   localparam logic [2:0] S_SETTLE     = 3'd2;
   localparam logic [2:0] S_CAPTURE    = 3'd3;
   localparam logic [2:0] S_WAIT_EMPTY = 3'd4;

   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);

   logic [2:0]      state;
   logic [CW-1:0]   cnt;
   logic [SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_nxt;

   logic push;
   logic pop;
   logic full;
   logic accept;
   logic drop;

   // The capture edge is the one that would take the settle counter to SETTLE
   // while in_empty is still low; the word is pushed on that same edge.
   always_comb begin
      push   = (state == S_SETTLE) && !in_empty && (cnt == CNT_LAST);
      pop    = out_valid && out_ready;
      full   = (level == LVL_FULL);
      accept = push && (!full || pop);
      drop   = push && full && !pop;
      rd_nxt = rd_ptr + AW'(1);
   end

   assign out_valid = (level != '0);

   // Detection stage: one word per in_empty low period, after a settle window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         glitch <= 1'b0;
      end else begin
         glitch <= 1'b0;
         case (state)
            // A low in_empty seen straight out of reset may be stale, so a
            // high level is required before arming.
            S_IDLE: begin
               if (in_empty) state <= S_ARMED;
            end
            S_ARMED: begin
               if (!in_empty) begin
                  state <= S_SETTLE;
                  cnt   <= '0;
               end
            end
            S_SETTLE: begin
               if (in_empty) begin
                  state  <= S_ARMED;
                  glitch <= 1'b1;
               end else if (cnt == CNT_LAST) begin
                  state <= S_CAPTURE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CAPTURE: begin
               state <= S_WAIT_EMPTY;
            end
            S_WAIT_EMPTY: begin
               if (in_empty) state <= S_ARMED;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage stage: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (!rst && accept) mem[wr_ptr] <= in_data;
   end

   // FIFO control stage: pointers, occupancy, head register and status.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         rx_count <= '0;
         out_data <= '0;
      end else begin
         if (accept) begin
            wr_ptr   <= wr_ptr + AW'(1);
            rx_count <= rx_count + 16'd1;
         end
         if (pop) rd_ptr <= rd_nxt;

         case ({accept, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         // Head register: an incoming word becomes head when the queue is
         // empty or its only word is leaving; otherwise a pop exposes the
         // next stored word (never the slot being written this cycle).
         if (accept && ((level == '0) || (pop && (level == LVL_ONE))))
            out_data <= in_data;
         else if (pop && (level > LVL_ONE))
            out_data <= mem[rd_nxt];

         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_reg_reader.sv
module tb_sync_reg_reader;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_empty;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        overflow;
   logic        ovf_clr;
   logic        glitch;
   logic [15:0] rx_count;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;

   sync_reg_reader #(.SIZE(8), .DEPTH(4), .SETTLE(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_empty  (in_empty),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .glitch    (glitch),
      .rx_count  (rx_count),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        e;
      logic [7:0]  d;
      logic        rdy;
      logic        clr;
      logic        vld;
      logic [7:0]  q;
      logic        ovf;
      logic        gl;
      logic [15:0] rx;
      logic [2:0]  lvl;
   } vec_t;

   vec_t tbl [19];

   task automatic step(input logic r, input logic e, input logic [7:0] d,
                       input logic rdy, input logic clr);
      rst       = r;
      in_empty  = e;
      in_data   = d;
      out_ready = rdy;
      ovf_clr   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Leaves the detector in WAIT_EMPTY; out_ready is high only on the push edge.
   task automatic send_word(input logic [7:0] d, input logic rdy_cap);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, d,     1'b0, 1'b0);
      step(1'b0, 1'b0, d,     1'b0, 1'b0);
      step(1'b0, 1'b0, d,     rdy_cap, 1'b0);
      step(1'b0, 1'b0, d,     1'b0, 1'b0);
   endtask

   // Leaves the detector in ARMED.
   task automatic do_reset();
      step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] drain3 [3];
      logic [7:0] drain4 [3];

      rst = 1'b1; in_empty = 1'b1; in_data = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;

      //          rst   e     d      rdy   clr   vld   q      ovf   gl    rx      lvl
      tbl[0]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0};
      tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0};
      tbl[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0};
      tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0};
      tbl[4]  = '{1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0};
      tbl[5]  = '{1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0};
      tbl[6]  = '{1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 16'd1, 3'd1};
      tbl[7]  = '{1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[8]  = '{1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[9]  = '{1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1, 3'd0};
      tbl[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[14] = '{1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[15] = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 3'd0};
      tbl[16] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 16'd2, 3'd1};
      tbl[17] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2, 3'd0};
      tbl[18] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2, 3'd0};

      // Single word, then glitch and a normal capture with changing in_data.
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].rst, tbl[i].e, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(tbl[i].vld));
         if (tbl[i].vld || tbl[i].rst)
            chk($sformatf("v%0d.data", i), 32'(out_data), 32'(tbl[i].q));
         chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(tbl[i].ovf));
         chk($sformatf("v%0d.glitch", i), 32'(glitch), 32'(tbl[i].gl));
         chk($sformatf("v%0d.rx", i), 32'(rx_count), 32'(tbl[i].rx));
         chk($sformatf("v%0d.level", i), 32'(level), 32'(tbl[i].lvl));
      end

      // Fill and overflow.
      do_reset();
      for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
      chk("fill.level", 32'(level), 32'd4);
      chk("fill.rx", 32'(rx_count), 32'd4);
      chk("fill.ovf", 32'(overflow), 32'd0);
      send_word(8'h05, 1'b0);
      chk("drop.level", 32'(level), 32'd4);
      chk("drop.rx", 32'(rx_count), 32'd4);
      chk("drop.ovf", 32'(overflow), 32'd1);
      chk("drop.head", 32'(out_data), 32'h01);
      drain3[0] = 8'h02; drain3[1] = 8'h03; drain3[2] = 8'h04;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
         chk($sformatf("drain3.%0d", i), 32'(out_data), 32'(drain3[i]));
      end
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      chk("drain3.empty", 32'(out_valid), 32'd0);
      chk("drain3.ovf_sticky", 32'(overflow), 32'd1);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Push and pop on the same edge while full.
      do_reset();
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      send_word(8'h33, 1'b0);
      send_word(8'h44, 1'b0);
      send_word(8'hA5, 1'b1);
      chk("fullpp.level", 32'(level), 32'd4);
      chk("fullpp.ovf", 32'(overflow), 32'd0);
      chk("fullpp.rx", 32'(rx_count), 32'd5);
      chk("fullpp.head", 32'(out_data), 32'h22);
      drain4[0] = 8'h33; drain4[1] = 8'h44; drain4[2] = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
         chk($sformatf("drain4.%0d", i), 32'(out_data), 32'(drain4[i]));
      end
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      chk("drain4.level", 32'(level), 32'd0);

      // Push and pop on the same edge with one word held.
      do_reset();
      send_word(8'h5A, 1'b0);
      chk("onepp.pre", 32'(out_data), 32'h5A);
      send_word(8'h6B, 1'b1);
      chk("onepp.valid", 32'(out_valid), 32'd1);
      chk("onepp.head", 32'(out_data), 32'h6B);
      chk("onepp.level", 32'(level), 32'd1);

      // Stale low in_empty across reset release.
      step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
      chk("stale.level", 32'(level), 32'd0);
      chk("stale.rx", 32'(rx_count), 32'd0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
      chk("stale.early", 32'(level), 32'd0);
      step(1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
      chk("stale.cap_level", 32'(level), 32'd1);
      chk("stale.cap_data", 32'(out_data), 32'h77);
      chk("stale.cap_rx", 32'(rx_count), 32'd1);

      // Reset in the middle of the settle window.
      do_reset();
      step(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
      chk("midrst.level", 32'(level), 32'd0);
      chk("midrst.rx", 32'(rx_count), 32'd0);
      chk("midrst.valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0);
      chk("midrst.recover", 32'(out_data), 32'hC3);
      chk("midrst.rx1", 32'(rx_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
